// File: rtl/sequence_pattern_detector_moore.sv
// Moore FSM flagging the serial pattern 1011 (overlapping) on sequence_in.
// Ports: clock, reset (async active-low), sequence_in, detector_out.
module sequence_pattern_detector_moore (
    input  logic clock,
    input  logic reset,
    input  logic sequence_in,
    output logic detector_out
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_10   = 3'd2,
        S_101  = 3'd3,
        S_1011 = 3'd4
    } state_e;

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = S_IDLE;
        detector_out = 1'b0;
        case (state_q)
            S_IDLE: state_d = sequence_in ? S_1 : S_IDLE;
            S_1:    state_d = sequence_in ? S_1 : S_10;
            S_10:   state_d = sequence_in ? S_101 : S_IDLE;
            // a 0 after "101" or "1011" still ends in "10"
            S_101:  state_d = sequence_in ? S_1011 : S_10;
            S_1011: begin
                detector_out = 1'b1;
                state_d      = sequence_in ? S_1 : S_10;
            end
            // unused encodings recover to idle
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sequence_pattern_detector_moore.sv
// Randomized and directed bench for sequence_pattern_detector_moore.
// Reference: last four bits sampled since reset equal 1011.
module tb_sequence_pattern_detector_moore;

    logic clock;
    logic reset;
    logic sequence_in;
    logic detector_out;

    int passed;
    int total;

    logic [3:0] hist;
    int         nbits;

    sequence_pattern_detector_moore dut (
        .clock       (clock),
        .reset       (reset),
        .sequence_in (sequence_in),
        .detector_out(detector_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic model_out();
        return (nbits >= 4) && (hist == 4'b1011);
    endfunction

    task automatic model_clear();
        hist  = 4'b0000;
        nbits = 0;
    endtask

    // drive one bit before the edge, sample 1 time unit after it
    task automatic step(input logic b);
        @(negedge clock);
        sequence_in = b;
        @(posedge clock);
        hist  = {hist[2:0], b};
        nbits = nbits + 1;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic exp;
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            sequence_in = i[0];
            @(posedge clock);
            #1;
            total++;
            if (detector_out !== 1'b0) begin
                $display("FAIL reset_hold out=%b exp=0", detector_out);
            end else begin
                passed++;
            end
            total++;
            if (dut.state_q !== 3'd0) begin
                $display("FAIL reset_state st=%0d exp=0", dut.state_q);
            end else begin
                passed++;
            end
            @(negedge clock);
        end
        reset = 1'b1;
        step(1'b1);
        step(1'b0);
        step(1'b1);
        step(1'b1);
        exp = model_out();
        total++;
        if (detector_out !== exp) begin
            $display("FAIL pre_async out=%b exp=%b", detector_out, exp);
        end else begin
            passed++;
        end
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        total++;
        if (detector_out !== 1'b0) begin
            $display("FAIL async_reset out=%b exp=0", detector_out);
        end else begin
            passed++;
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [13:0] seq;
        int pulses;
        int first;
        logic exp;
        seq    = 14'b00001011001100;
        pulses = 0;
        first  = -1;
        apply_reset();
        for (int i = 0; i < 14; i++) begin
            step(seq[13-i]);
            exp = model_out();
            total++;
            if (detector_out !== exp) begin
                $display("FAIL basic bit%0d out=%b exp=%b",
                         i + 1, detector_out, exp);
            end else begin
                passed++;
            end
            if (detector_out === 1'b1) begin
                pulses++;
                if (first < 0) first = i + 1;
            end
        end
        total++;
        if (pulses !== 1 || first !== 8) begin
            $display("FAIL basic_pulse n=%0d at=%0d exp n=1 at=8",
                     pulses, first);
        end else begin
            passed++;
        end
    endtask

    task automatic test_overlap();
        logic [6:0] seq;
        logic [6:0] got;
        logic [6:0] want;
        seq  = 7'b1011011;
        want = 7'b0001001;
        got  = '0;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            step(seq[6-i]);
            got[6-i] = detector_out;
        end
        total++;
        if (got !== want) begin
            $display("FAIL overlap got=%b exp=%b", got, want);
        end else begin
            passed++;
        end
    endtask

    task automatic test_near_miss();
        logic [4:0] a;
        logic [5:0] b;
        int hits;
        a    = 5'b10011;
        b    = 6'b111001;
        hits = 0;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            step(a[4-i]);
            if (detector_out !== 1'b0) hits++;
        end
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            step(b[5-i]);
            if (detector_out !== 1'b0) hits++;
        end
        total++;
        if (hits !== 0) begin
            $display("FAIL near_miss hits=%0d exp=0", hits);
        end else begin
            passed++;
        end
    endtask

    task automatic test_suffix_reuse();
        logic [5:0] seq;
        logic [5:0] got;
        seq = 6'b101011;
        got = '0;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            step(seq[5-i]);
            got[5-i] = detector_out;
            if (i == 3) begin
                total++;
                if (dut.state_q !== 3'd2) begin
                    $display("FAIL suffix_state st=%0d exp=2",
                             dut.state_q);
                end else begin
                    passed++;
                end
            end
        end
        total++;
        if (got !== 6'b000001) begin
            $display("FAIL suffix_pulse got=%b exp=000001", got);
        end else begin
            passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] seq;
        logic [4:0] got;
        logic exp;
        apply_reset();
        step(1'b1);
        step(1'b0);
        step(1'b1);
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        #2;
        reset = 1'b1;
        step(1'b1);
        total++;
        if (detector_out !== 1'b0) begin
            $display("FAIL reset_mid out=%b exp=0", detector_out);
        end else begin
            passed++;
        end
        seq = 5'b01100;
        for (int i = 0; i < 3; i++) begin
            step(seq[4-i]);
            exp = model_out();
            total++;
            if (detector_out !== exp) begin
                $display("FAIL reset_mid_tail bit%0d out=%b exp=%b",
                         i + 1, detector_out, exp);
            end else begin
                passed++;
            end
        end
        apply_reset();
        seq = 5'b11011;
        got = '0;
        for (int i = 0; i < 5; i++) begin
            step(seq[4-i]);
            got[4-i] = detector_out;
        end
        total++;
        if (got !== 5'b00001) begin
            $display("FAIL reset_restart got=%b exp=00001", got);
        end else begin
            passed++;
        end
    endtask

    task automatic test_random();
        int errs;
        int pulses;
        int want;
        logic exp;
        errs   = 0;
        pulses = 0;
        want   = 0;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                apply_reset();
            end
            step(1'($urandom_range(0, 1)));
            exp = model_out();
            if (exp) want++;
            if (detector_out === 1'b1) pulses++;
            total++;
            if (detector_out !== exp) begin
                errs++;
                if (errs < 10) begin
                    $display("FAIL random cyc%0d out=%b exp=%b",
                             i, detector_out, exp);
                end
            end else begin
                passed++;
            end
        end
        total++;
        if (pulses !== want) begin
            $display("FAIL random_count got=%0d exp=%0d", pulses, want);
        end else begin
            passed++;
        end
    endtask

    initial begin
        passed      = 0;
        total       = 0;
        reset       = 1'b0;
        sequence_in = 1'b0;
        model_clear();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        test_reset();
        test_basic();
        test_overlap();
        test_near_miss();
        test_suffix_reuse();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
